// File: rtl/game_pkg.sv
// game_pkg: shared types, constants and BCD helpers for the game countdown.
//   gc_state_t   - countdown FSM states
//   gc_time_t    - packed BCD time M:SS.t
//   SEG_*        - active-low seven-segment patterns (gfedcba)
//   bcd_dec      - subtract 0.1 s with BCD borrow, holds at 0:00.0
//   bcd_add_sec  - add whole seconds with carry, saturates at 9:59.9
//   bcd_is_zero  - true when the time reads 0:00.0
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } gc_state_t;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] s10;
        logic [3:0] s1;
        logic [3:0] t;
    } gc_time_t;

    localparam logic [3:0] MAX_M   = 4'd9;
    localparam logic [3:0] MAX_S10 = 4'd5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic logic bcd_is_zero(input gc_time_t v);
        return (v == 16'h0000);
    endfunction

    // Zero is a fixed point so the count never wraps to 9:59.9.
    function automatic gc_time_t bcd_dec(input gc_time_t v);
        gc_time_t r;
        r = v;
        if (bcd_is_zero(v)) begin
            r = v;
        end else if (v.t != 4'd0) begin
            r.t = v.t - 4'd1;
        end else begin
            r.t = 4'd9;
            if (v.s1 != 4'd0) begin
                r.s1 = v.s1 - 4'd1;
            end else begin
                r.s1 = 4'd9;
                if (v.s10 != 4'd0) begin
                    r.s10 = v.s10 - 4'd1;
                end else begin
                    r.s10 = MAX_S10;
                    r.m   = v.m - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Seconds are summed in binary (max 59+9) and split back into BCD;
    // a carry out of 9 minutes pins every digit at its maximum.
    function automatic gc_time_t bcd_add_sec(input gc_time_t v, input logic [3:0] bonus);
        gc_time_t   r;
        logic [6:0] secs;
        logic       carry;
        r     = v;
        secs  = {3'b000, v.s10} * 7'd10 + {3'b000, v.s1} + {3'b000, bonus};
        carry = (secs >= 7'd60);
        if (carry) begin
            secs = secs - 7'd60;
        end else begin
            secs = secs;
        end
        if (carry && (v.m == MAX_M)) begin
            r = '{m: MAX_M, s10: MAX_S10, s1: 4'd9, t: 4'd9};
        end else begin
            r.m   = carry ? (v.m + 4'd1) : v.m;
            r.s10 = 4'(secs / 7'd10);
            r.s1  = 4'(secs % 7'd10);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit to active-low seven-segment decoder.
//   bcd_i [3:0]  digit value; 10-15 show blank
//   seg_o [6:0]  segments gfedcba, 0 = lit
module bcd_to_7seg
    import game_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Digit lookup; non-decimal codes blank the display.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_countdown.sv
// game_countdown: M:SS.t countdown driven by the 0.1 s game tick.
//   CLOCK50M        system clock
//   KEY0            asynchronous active-low reset
//   tick            game tick; each rising edge removes 0.1 s
//   start           pulse: (re)start from the initial time (IDLE/DONE only)
//   pause           level: hold the countdown while high
//   add_time        pulse: add BONUS_S seconds (RUN/PAUSE only)
//   HEX3..HEX0      minutes, seconds tens, seconds units, tenths (active-low)
//   running         high while the FSM is in RUN
//   time_up         one-cycle pulse when the count reaches 0:00.0
module game_countdown
    import game_pkg::*;
#(
    parameter int INIT_M  = 1,
    parameter int INIT_S  = 30,
    parameter int INIT_T  = 0,
    parameter int BONUS_S = 5
) (
    input  logic       CLOCK50M,
    input  logic       KEY0,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       add_time,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       running,
    output logic       time_up
);

    localparam gc_time_t INIT_V = '{
        m:   4'(INIT_M),
        s10: 4'(INIT_S / 10),
        s1:  4'(INIT_S % 10),
        t:   4'(INIT_T)
    };
    localparam gc_time_t   ZERO_V = 16'h0000;
    localparam logic [3:0] BONUS  = 4'(BONUS_S);

    gc_state_t state_q;
    gc_time_t  digits_q;
    logic      tick_d_q;
    logic      running_q;
    logic      time_up_q;

    logic      tick_edge_s;
    gc_time_t  added_s;
    gc_time_t  stepped_s;
    logic      done_hit_s;

    // Same-cycle ordering: bonus first, then the tick decrement, then zero test.
    // Zero can only be reached by a decrement, so the test is gated by the edge.
    always_comb begin
        tick_edge_s = tick & ~tick_d_q;
        added_s     = add_time ? bcd_add_sec(digits_q, BONUS) : digits_q;
        stepped_s   = tick_edge_s ? bcd_dec(added_s) : added_s;
        done_hit_s  = tick_edge_s && bcd_is_zero(stepped_s);
    end

    // Countdown FSM with registered running/time_up flags.
    always_ff @(posedge CLOCK50M or negedge KEY0) begin
        if (!KEY0) begin
            state_q   <= IDLE;
            digits_q  <= INIT_V;
            tick_d_q  <= 1'b0;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            tick_d_q  <= tick;
            time_up_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    digits_q <= INIT_V;
                    if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                RUN: begin
                    digits_q <= stepped_s;
                    if (done_hit_s) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        time_up_q <= 1'b1;
                    end else if (pause) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else begin
                        running_q <= 1'b1;
                    end
                end
                PAUSE: begin
                    // Ticks are ignored here; only a bonus may change the time.
                    digits_q <= added_s;
                    if (!pause) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (start) begin
                        digits_q  <= INIT_V;
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else begin
                        digits_q  <= ZERO_V;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    digits_q  <= INIT_V;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running = running_q;
    assign time_up = time_up_q;

    bcd_to_7seg u_hex3 (.bcd_i(digits_q.m),   .seg_o(HEX3));
    bcd_to_7seg u_hex2 (.bcd_i(digits_q.s10), .seg_o(HEX2));
    bcd_to_7seg u_hex1 (.bcd_i(digits_q.s1),  .seg_o(HEX1));
    bcd_to_7seg u_hex0 (.bcd_i(digits_q.t),   .seg_o(HEX0));

endmodule

// File: tb/tb_game_countdown.sv
module tb_game_countdown;

    logic       CLOCK50M = 1'b0;
    logic       KEY0     = 1'b0;
    logic       tick     = 1'b0;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic       add_time = 1'b0;
    logic [6:0] HEX3, HEX2, HEX1, HEX0;
    logic       running, time_up;

    int n_cmp = 0;
    int n_bad = 0;
    int tu_count = 0;

    game_countdown #(
        .INIT_M(1), .INIT_S(30), .INIT_T(0), .BONUS_S(5)
    ) dut (
        .CLOCK50M(CLOCK50M), .KEY0(KEY0), .tick(tick), .start(start),
        .pause(pause), .add_time(add_time),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .running(running), .time_up(time_up)
    );

    always #10 CLOCK50M = ~CLOCK50M;

    always @(negedge CLOCK50M) begin
        if (time_up === 1'b1) tu_count++;
    end

    // Independent active-low gfedcba table.
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] exp_hex(input int m, input int s10, input int s1, input int t);
        return {seg(m), seg(s10), seg(s1), seg(t)};
    endfunction

    task automatic cycle();
        @(posedge CLOCK50M);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
    endtask

    task automatic test_reset();
        KEY0 = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(1, 3, 0, 0)) begin
            n_bad++; $display("FAIL reset_digits: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(1, 3, 0, 0));
        end
        n_cmp++;
        if ({running, time_up} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00", {running, time_up});
        end
        KEY0 = 1'b1;
        cycle();
    endtask

    task automatic test_start_count();
        start = 1'b1; cycle(); start = 1'b0;
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++; $display("FAIL start_running: got %b want 1", running);
        end
        ticks(3);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(1, 2, 9, 7)) begin
            n_bad++; $display("FAIL count_1_29_7: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(1, 2, 9, 7));
        end
        n_cmp++;
        if ({HEX3, HEX0, running} !== {7'h79, 7'h78, 1'b1}) begin
            n_bad++; $display("FAIL hex3_hex0_run: got %h %h %b want 79 78 1", HEX3, HEX0, running);
        end
    endtask

    task automatic test_minute_borrow();
        ticks(297);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(1, 0, 0, 0)) begin
            n_bad++; $display("FAIL at_1_00_0: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(1, 0, 0, 0));
        end
        ticks(1);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 5, 9, 9)) begin
            n_bad++; $display("FAIL borrow_0_59_9: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 5, 9, 9));
        end
    endtask

    task automatic test_long_tick();
        tick = 1'b1;
        repeat (5) cycle();
        tick = 1'b0;
        cycle();
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 5, 9, 8)) begin
            n_bad++; $display("FAIL long_tick_once: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 5, 9, 8));
        end
    endtask

    task automatic test_add_with_tick();
        ticks(18);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 5, 8, 0)) begin
            n_bad++; $display("FAIL at_0_58_0: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 5, 8, 0));
        end
        add_time = 1'b1; tick = 1'b1; cycle();
        add_time = 1'b0; tick = 1'b0; cycle();
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(1, 0, 2, 9)) begin
            n_bad++; $display("FAIL add_tick_1_02_9: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(1, 0, 2, 9));
        end
    endtask

    task automatic test_pause();
        ticks(176);
        start = 1'b1; cycle(); start = 1'b0; cycle();
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 4, 5, 3)) begin
            n_bad++; $display("FAIL start_ignored_0_45_3: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 4, 5, 3));
        end
        pause = 1'b1; cycle();
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++; $display("FAIL pause_running: got %b want 0", running);
        end
        ticks(10);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 4, 5, 3)) begin
            n_bad++; $display("FAIL paused_hold: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 4, 5, 3));
        end
        pause = 1'b0; cycle();
        ticks(1);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0, running} !== {exp_hex(0, 4, 5, 2), 1'b1}) begin
            n_bad++; $display("FAIL resume_0_45_2: got %h run %b want %h run 1", {HEX3, HEX2, HEX1, HEX0}, running, exp_hex(0, 4, 5, 2));
        end
    endtask

    task automatic test_time_up();
        int tu0;
        ticks(450);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 0, 0, 2)) begin
            n_bad++; $display("FAIL at_0_00_2: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 0, 0, 2));
        end
        ticks(1);
        tu0 = tu_count;
        n_cmp++;
        if (time_up !== 1'b0) begin
            n_bad++; $display("FAIL early_time_up: got %b want 0", time_up);
        end
        tick = 1'b1; cycle();
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0, time_up, running} !== {exp_hex(0, 0, 0, 0), 2'b10}) begin
            n_bad++; $display("FAIL reach_zero: got %h tu %b run %b want %h tu 1 run 0", {HEX3, HEX2, HEX1, HEX0}, time_up, running, exp_hex(0, 0, 0, 0));
        end
        tick = 1'b0; cycle();
        n_cmp++;
        if (time_up !== 1'b0) begin
            n_bad++; $display("FAIL time_up_width: got %b want 0", time_up);
        end
        ticks(3);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 0, 0, 0)) begin
            n_bad++; $display("FAIL done_hold_zero: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 0, 0, 0));
        end
        n_cmp++;
        if (tu_count !== tu0 + 1) begin
            n_bad++; $display("FAIL time_up_pulses: got %0d want %0d", tu_count - tu0, 1);
        end
    endtask

    task automatic test_restart_done();
        start = 1'b1; cycle(); start = 1'b0;
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0, running} !== {exp_hex(1, 3, 0, 0), 1'b1}) begin
            n_bad++; $display("FAIL restart: got %h run %b want %h run 1", {HEX3, HEX2, HEX1, HEX0}, running, exp_hex(1, 3, 0, 0));
        end
    endtask

    task automatic test_saturate();
        ticks(30);
        pause = 1'b1; cycle();
        repeat (102) begin
            add_time = 1'b1; cycle();
            add_time = 1'b0; cycle();
        end
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(9, 5, 7, 0)) begin
            n_bad++; $display("FAIL add_to_9_57_0: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(9, 5, 7, 0));
        end
        add_time = 1'b1; cycle(); add_time = 1'b0; cycle();
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(9, 5, 9, 9)) begin
            n_bad++; $display("FAIL saturate_9_59_9: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(9, 5, 9, 9));
        end
        pause = 1'b0; cycle();
    endtask

    task automatic test_async_reset();
        int tu0;
        KEY0 = 1'b0; cycle(); KEY0 = 1'b1; cycle();
        start = 1'b1; cycle(); start = 1'b0;
        ticks(776);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex(0, 1, 2, 4)) begin
            n_bad++; $display("FAIL at_0_12_4: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex(0, 1, 2, 4));
        end
        tu0 = tu_count;
        #4;
        KEY0 = 1'b0;
        #1;
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0, running, time_up} !== {exp_hex(1, 3, 0, 0), 2'b00}) begin
            n_bad++; $display("FAIL async_reset: got %h run %b tu %b want %h 0 0", {HEX3, HEX2, HEX1, HEX0}, running, time_up, exp_hex(1, 3, 0, 0));
        end
        #5;
        KEY0 = 1'b1;
        ticks(2);
        n_cmp++;
        if ({HEX3, HEX2, HEX1, HEX0, running} !== {exp_hex(1, 3, 0, 0), 1'b0}) begin
            n_bad++; $display("FAIL idle_after_reset: got %h run %b want %h run 0", {HEX3, HEX2, HEX1, HEX0}, running, exp_hex(1, 3, 0, 0));
        end
        n_cmp++;
        if (tu_count !== tu0) begin
            n_bad++; $display("FAIL reset_no_time_up: got %0d pulses want 0", tu_count - tu0);
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_minute_borrow();
        test_long_tick();
        test_add_with_tick();
        test_pause();
        test_time_up();
        test_restart_done();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_countdown.md
# game_countdown

Countdown timer stage that consumes the 0.1 s game tick pulse from the game clock and keeps the remaining play time as BCD M:SS.t. It sequences start/pause/resume/time-up through a small state machine and drives four active-low seven-segment digits. It also emits a one-cycle time-up pulse to the game logic downstream.

## Interface
- INIT_M, 1: initial minutes, 0–9
- INIT_S, 30: initial seconds, 0–59
- INIT_T, 0: initial tenths, 0–9
- BONUS_S, 5: whole seconds added per `add_time`, 1–9

Ports:
- CLOCK50M  in  1  system clock, 50 MHz
- KEY0  in  1  reset, asynchronous, active-low
- tick  in  1  game tick from game clock; rising edge = 0.1 s elapsed; may be high more than one cycle
- start  in  1  one-cycle pulse; start or restart the game
- pause  in  1  level; 1 = hold countdown
- add_time  in  1  one-cycle pulse; add BONUS_S seconds
- HEX3  out  7  minutes digit, segments gfedcba, active-low
- HEX2  out  7  seconds tens
- HEX1  out  7  seconds units
- HEX0  out  7  tenths
- running  out  1  1 while in state RUN
- time_up  out  1  one-cycle pulse when the count reaches 0:00.0

## Operation
- Digits are `m`, `s10` (0–5), `s1`, and `t`, each a 4-bit BCD register.
- Tick edge: `tick_d` registers `tick`; the edge condition is `tick & ~tick_d`. One decrement happens per rising edge, however long `tick` stays high.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: digits hold INIT. On `start`, reload INIT and go to RUN.
- RUN:
  - On a tick edge, decrement by 0.1 s with BCD borrow: t 0→9 borrows s1, s1 0→9 borrows s10, s10 0→5 borrows m.
  - `pause=1` goes to PAUSE.
  - If the post-update value is 0:00.0, go to DONE.
- PAUSE: digits frozen and tick edges ignored. `pause=0` returns to RUN.
- DONE: digits hold 0:00.0. On `start`, reload INIT and go to RUN.
- `start` in RUN or PAUSE is ignored.
- `add_time` is honoured in RUN and PAUSE only. It adds BONUS_S to the seconds field with carry into minutes and saturates at 9:59.9.
- Priority in the same cycle:
  1. Apply `add_time` first.
  2. Then apply the tick decrement (net +BONUS_S−0.1 s).
  3. Then evaluate the zero check.
  4. `pause` is evaluated on the same edge; a tick arriving on the edge that enters PAUSE still decrements.
- Decrement is never applied at 0:00.0, so there is no wrap to 9:59.9.
- INIT of 0:00.0 is allowed: `start` enters RUN, and the first tick edge holds 0:00.0, pulses `time_up` and goes to DONE.

## Timing
- Reset values: state IDLE; digits INIT; `tick_d`=0; `running`=0; `time_up`=0; HEX outputs show INIT.
- Digit update is visible one cycle after the clock edge that samples the tick rising edge.
- HEX outputs are combinational decodes of the digit registers, adding zero cycles.
- `running` is registered and follows the state with one-cycle latency relative to the transition edge.
- `time_up` is registered and high for exactly the cycle after the edge that reached 0:00.0, coincident with state DONE.
- Reset asserted mid-run: everything returns to reset values immediately, with no `time_up` pulse.

## Structure
- Shared package `game_pkg` holds:
  - state enum `gc_state_t` {IDLE, RUN, PAUSE, DONE}
  - 7-seg constants for blank and 0–9, active-low
  - `MAX_M=9`, `MAX_S10=5`
- Sub-module `bcd_to_7seg` holds the 4-bit to 7-bit active-low decoder. Values 10–15 decode to blank, 7'h7F. It is instantiated four times.
- BCD decrement and saturating add are functions in the package.

## Test plan
- Reset then `start` with INIT 1:30.0, then 3 tick edges: digits 1:29.7, `running`=1, HEX3=7'h79 (1), HEX0=7'h78 (7).
- Count from 1:00.0 with 1 tick: 0:59.9. From 0:00.2 with 2 ticks: 0:00.0, `time_up` high exactly 1 cycle, state DONE; further ticks leave 0:00.0.
- `tick` held high 5 cycles: exactly one decrement.
- `add_time` plus a tick edge in the same cycle at 0:58.0: result 1:02.9. `add_time` at 9:57.0: 9:59.9 (saturated).
- `pause=1` at 0:45.3, then 10 tick edges: digits stay 0:45.3. `pause=0` plus 1 tick: 0:45.2.
- KEY0 low in RUN at 0:12.4: digits back to 1:30.0 asynchronously, `running`=0, no `time_up`. `start` in DONE: reload to 1:30.0 and go to RUN.
